// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, parity encoding and receiver states.
// The transmitter uses the same parity encoding.
package uart_pkg;

    localparam int DATA_W = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } rx_state_e;

    // Parity bit a correct frame carries for byte d under encoding typ.
    function automatic logic par_bit(input logic [DATA_W-1:0] d, input logic typ);
        return (^d) ^ typ;
    endfunction

endpackage

// File: rtl/rx_if.sv
// Serial input, frame configuration and parallel result bus of the UART receiver.
interface rx_if;
    import uart_pkg::*;

    logic              i_rx;
    logic              i_par_en;
    logic              i_par_typ;
    logic [DATA_W-1:0] o_p_data;
    logic              o_data_valid;
    logic              o_par_err;
    logic              o_stop_err;
    logic              o_busy;

    modport master (
        output i_rx, i_par_en, i_par_typ,
        input  o_p_data, o_data_valid, o_par_err, o_stop_err, o_busy
    );

    modport slave (
        input  i_rx, i_par_en, i_par_typ,
        output o_p_data, o_data_valid, o_par_err, o_stop_err, o_busy
    );

endinterface

// File: rtl/rx_bit_sync.sv
// Flop-chain synchroniser for an idle-high line; flops reset to 1 so reset
// never looks like a start bit. STAGES == 0 passes the input straight through.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_arst_n,
    input  logic i_d,
    output logic o_q
);

    generate
        if (STAGES == 0) begin : g_bypass
            assign o_q = i_d;
        end else begin : g_chain
            logic [STAGES-1:0] ff;

            always_ff @(posedge i_clk or negedge i_arst_n) begin
                if (!i_arst_n) begin
                    ff <= '1;
                end else begin
                    ff[0] <= i_d;
                    for (int i = 1; i < STAGES; i++) begin
                        ff[i] <= ff[i-1];
                    end
                end
            end

            assign o_q = ff[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/rx.sv
// UART receiver: start detect, 8 data bits LSB first, optional parity, stop check.
// Delivers every frame with a one-clock valid strobe; error flags qualify it.
module rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic i_clk,
    input  logic i_arst_n,
    rx_if.slave  bus
);

    localparam int              CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] MID   = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       IDX_LAST = 3'(DATA_W - 1);

    logic              s_rx;
    rx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic              par_en_q, par_typ_q, par_err_q;
    logic [DATA_W-1:0] shift_q;
    logic              latch_cfg, shift_en, par_chk, stop_chk;
    logic              at_mid, at_last;

    bit_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .i_clk    (i_clk),
        .i_arst_n (i_arst_n),
        .i_d      (bus.i_rx),
        .o_q      (s_rx)
    );

    assign at_mid  = (cnt_q == MID);
    assign at_last = (cnt_q == LAST);

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = at_last ? '0 : cnt_q + 1'b1;
        idx_d     = idx_q;
        latch_cfg = 1'b0;
        shift_en  = 1'b0;
        par_chk   = 1'b0;
        stop_chk  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!s_rx) begin
                    latch_cfg = 1'b1;
                    // The detecting clock is cnt 0 of the start bit; with one
                    // clock per bit the start bit is already over.
                    if (CLKS_PER_BIT == 1) begin
                        state_d = DATA;
                    end else begin
                        state_d = START;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            START: begin
                if (at_mid && s_rx) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (at_last) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                shift_en = at_mid;
                if (at_last) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q == IDX_LAST) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                par_chk = at_mid;
                if (at_last) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (at_mid) begin
                    // Leave mid-stop so a back-to-back start bit is caught.
                    stop_chk = 1'b1;
                    cnt_d    = '0;
                    state_d  = s_rx ? IDLE : WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                cnt_d = '0;
                if (s_rx) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (shift_en) begin
            shift_q[idx_q] <= s_rx;
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            par_en_q         <= 1'b0;
            par_typ_q        <= 1'b0;
            par_err_q        <= 1'b0;
            bus.o_p_data     <= '0;
            bus.o_data_valid <= 1'b0;
            bus.o_par_err    <= 1'b0;
            bus.o_stop_err   <= 1'b0;
        end else begin
            bus.o_data_valid <= stop_chk;
            if (latch_cfg) begin
                par_en_q  <= bus.i_par_en;
                par_typ_q <= bus.i_par_typ;
                par_err_q <= 1'b0;
            end
            if (par_chk) begin
                par_err_q <= par_bit(shift_q, par_typ_q) ^ s_rx;
            end
            if (stop_chk) begin
                bus.o_p_data   <= shift_q;
                bus.o_par_err  <= par_err_q;
                bus.o_stop_err <= ~s_rx;
            end
        end
    end

    assign bus.o_busy = (state_q != IDLE);

endmodule
